// File: rtl/disp_pkg.sv
//==============================================================================
// Module   : disp_pkg
// Purpose  : Shared display constants, the segment codes and the snapshot record.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package disp_pkg;

   localparam int DIGITS = 8;
   localparam int DP_BIT = 7;

   localparam logic [7:0] SEG_OFF = 8'h00;
   localparam logic [7:0] LEG_OFF = 8'hFF;

   // Segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;

   typedef struct packed {
      logic [4*DIGITS-1:0] digits;
      logic [DIGITS-1:0]   dp;
      logic [DIGITS-1:0]   blank;
      logic [DIGITS-1:0]   blink;
   } snap_t;

   function automatic logic [DIGITS-1:0] leg_sel(input logic [2:0] idx);
      return ~(8'b1 << idx);
   endfunction

endpackage

`default_nettype wire

// File: rtl/disp_scan_if.sv
//==============================================================================
// Module   : disp_scan_if
// Purpose  : Digit/mask inputs and the leg/dis scan bus of one display source.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface disp_scan_if;
   import disp_pkg::*;

   logic [4*DIGITS-1:0] digits;
   logic [DIGITS-1:0]   dp_mask;
   logic [DIGITS-1:0]   blank_mask;
   logic [DIGITS-1:0]   blink_mask;
   logic [DIGITS-1:0]   leg;
   logic [7:0]          dis;
   logic                frame_done;

   // master: the scan driver; slave: whoever supplies digits and consumes the bus
   modport master (
      input  digits, dp_mask, blank_mask, blink_mask,
      output leg, dis, frame_done
   );

   modport slave (
      output digits, dp_mask, blank_mask, blink_mask,
      input  leg, dis, frame_done
   );

endinterface

`default_nettype wire

// File: rtl/seg7_enc.sv
//==============================================================================
// Module   : seg7_enc
// Purpose  : Combinational BCD to seven-segment decode; non-BCD codes go dark.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module seg7_enc
   import disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h00;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = 7'h00;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/disp_scan.sv
//==============================================================================
// Module   : disp_scan
// Purpose  : 8-digit time-multiplexed seven-segment scan driver with per-frame
//            input snapshot. Optional digit blinking under DISP_SCAN_BLINK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module disp_scan
   import disp_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 16
)(
   input  logic        clk,
   input  logic        rst_n,
   disp_scan_if.master bus
);

   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_idx;
   snap_t             r_snap;
   logic              r_wrap;
   logic              r_frame_done;
   logic [DIGITS-1:0] r_leg;
   logic [7:0]        r_dis;

   logic              w_tick;
   logic              w_frame_end;
   logic              w_phase;
   snap_t             w_snap_in;
   logic [3:0]        w_nib;
   logic [6:0]        w_seg;
   logic [7:0]        w_dis;

   assign w_tick      = (r_cnt == c_cnt_last);
   assign w_frame_end = w_tick && (r_idx == 3'd7);

   always_comb begin
      w_snap_in        = '0;
      w_snap_in.digits = bus.digits;
      w_snap_in.dp     = bus.dp_mask;
      w_snap_in.blank  = bus.blank_mask;
`ifdef DISP_SCAN_BLINK_EN
      w_snap_in.blink  = bus.blink_mask;
`else
      w_snap_in.blink  = '0;
`endif
   end

`ifdef DISP_SCAN_BLINK_EN
   localparam int FC_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FC_W-1:0] c_fc_last = FC_W'(BLINK_FRAMES - 1);

   logic [FC_W-1:0] r_fcnt;
   logic            r_phase;

   // Phase flips at the end of the last frame of a half-period so that the
   // first digit of the following frame already sees the new phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fcnt  <= '0;
         r_phase <= 1'b0;
      end else if (w_frame_end) begin
         if (r_fcnt == c_fc_last) begin
            r_fcnt  <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_fcnt  <= r_fcnt + FC_W'(1);
         end
      end
   end

   assign w_phase = r_phase;
`else
   localparam int c_unused_blink_frames = BLINK_FRAMES;
   logic w_unused_blink;
   assign w_unused_blink = ^bus.blink_mask;
   assign w_phase        = 1'b0;
`endif

   assign w_nib = r_snap.digits[{r_idx, 2'b00} +: 4];

   seg7_enc u_seg7_enc (
      .bcd (w_nib),
      .seg (w_seg)
   );

   always_comb begin
      w_dis = {r_snap.dp[r_idx], w_seg};
      if (r_snap.blank[r_idx] || (w_phase && r_snap.blink[r_idx])) begin
         w_dis = SEG_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_idx        <= 3'd0;
         r_snap       <= '0;
         r_wrap       <= 1'b0;
         r_frame_done <= 1'b0;
         r_leg        <= LEG_OFF;
         r_dis        <= SEG_OFF;
      end else begin
         if (w_tick) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_frame_end) begin
            r_snap <= w_snap_in;
         end
         // frame_done is delayed one extra cycle to line up with the lagged outputs
         r_wrap       <= w_frame_end;
         r_frame_done <= r_wrap;
         r_leg        <= leg_sel(r_idx);
         r_dis        <= w_dis;
      end
   end

   assign bus.leg        = r_leg;
   assign bus.dis        = r_dis;
   assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_disp_scan.sv
//==============================================================================
// Module   : tb_disp_scan
// Purpose  : Self-checking bench for disp_scan (SCAN_DIV=4, BLINK_FRAMES=2).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_disp_scan;
   import disp_pkg::*;

   localparam int S     = 4;
   localparam int BF    = 2;
   localparam int FRAME = 8 * S;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   disp_scan_if bus ();

   disp_scan #(.SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 60)
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: frame/slot arithmetic ----------------
   typedef struct {
      logic [31:0] d;
      logic [7:0]  dp;
      logic [7:0]  bl;
      logic [7:0]  bk;
   } snap_s;

   logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
   snap_s snaps [$];
   int    n = 0;
   bit    seen_reset = 1'b0;

   always @(posedge clk) begin
      snap_s      cur, s;
      logic [7:0] e_leg, e_dis;
      logic       e_fd;
      int         p, f, k;
      cur = '{bus.digits, bus.dp_mask, bus.blank_mask, bus.blink_mask};
      if (!rst_n) begin
         seen_reset = 1'b1;
         n = 0;
         snaps.delete();
         snaps.push_back('{32'h0, 8'h0, 8'h0, 8'h0});
      end else if (seen_reset) begin
         n++;
         if (n % FRAME == 0) snaps.push_back(cur);
      end
      #1;
      if (seen_reset) begin
         if (n == 0) begin
            e_leg = 8'hFF; e_dis = 8'h00; e_fd = 1'b0;
         end else begin
            p = n - 1;
            f = p / FRAME;
            k = (p / S) % 8;
            s = snaps[f];
            e_leg = 8'hFF ^ (8'h01 << k);
            e_dis = s.bl[k] ? 8'h00 : {s.dp[k], segtab[s.d[4*k +: 4]]};
`ifdef DISP_SCAN_BLINK_EN
            if (((f / BF) % 2) == 1 && s.bk[k]) e_dis = 8'h00;
`endif
            e_fd = (n > 1) && (n % FRAME == 1);
         end
         chk("model_leg", bus.leg, e_leg);
         chk("model_dis", bus.dis, e_dis);
         chk("model_frame_done", bus.frame_done, e_fd);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_fd();
      bit ok = 1'b0;
      for (int i = 0; i < 2*FRAME; i++) begin
         @(negedge clk);
         if (bus.frame_done) begin ok = 1'b1; break; end
      end
      chk("frame_done_timeout", ok, 1'b1);
   endtask

   task automatic wait_leg(input logic [7:0] v);
      bit ok = 1'b0;
      for (int i = 0; i < 2*FRAME; i++) begin
         @(negedge clk);
         if (bus.leg == v) begin ok = 1'b1; break; end
      end
      chk("leg_wait_timeout", ok, 1'b1);
   endtask

   typedef struct {
      logic [31:0] d;
      logic [7:0]  dp;
      logic [7:0]  bl;
      logic [7:0]  e [8];
   } vec_t;

   vec_t tbl [5];
   int   fd_cnt;

   initial begin
      tbl[0] = '{32'h76543210, 8'h00, 8'h00, '{8'h3F,8'h06,8'h5B,8'h4F,8'h66,8'h6D,8'h7D,8'h07}};
      tbl[1] = '{32'h99999999, 8'h00, 8'h00, '{8'h6F,8'h6F,8'h6F,8'h6F,8'h6F,8'h6F,8'h6F,8'h6F}};
      tbl[2] = '{32'h8C543210, 8'h04, 8'h80, '{8'h3F,8'h06,8'hDB,8'h4F,8'h66,8'h6D,8'h00,8'h00}};
      tbl[3] = '{32'hFEDCBA98, 8'hFC, 8'h00, '{8'h7F,8'h6F,8'h80,8'h80,8'h80,8'h80,8'h80,8'h80}};
      tbl[4] = '{32'h13572468, 8'h01, 8'h02, '{8'hFF,8'h00,8'h66,8'h5B,8'h07,8'h6D,8'h4F,8'h06}};

      bus.digits = 32'h76543210; bus.dp_mask = 8'h00;
      bus.blank_mask = 8'h00;    bus.blink_mask = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_leg", bus.leg, 8'hFF);
      chk("reset_dis", bus.dis, 8'h00);
      chk("reset_frame_done", bus.frame_done, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_leg", bus.leg, 8'hFE);
      chk("first_dis_zero_snapshot", bus.dis, 8'h3F);

      // Frame 1 shows 76543210; change inputs mid-frame at idx 3
      wait_fd();
      wait_leg(8'hF7);
      bus.digits = 32'h99999999;
      repeat (S) @(negedge clk);
      chk("midframe_leg", bus.leg, 8'hEF);
      chk("midframe_old_dis", bus.dis, 8'h66);
      wait_fd();
      chk("next_frame_new_dis", bus.dis, 8'h6F);

      // Exactly one frame_done per frame
      fd_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (bus.frame_done) fd_cnt++;
      end
      chk("frame_done_per_frame", fd_cnt, 1);

      for (int v = 0; v < 5; v++) begin
         bus.digits = tbl[v].d; bus.dp_mask = tbl[v].dp; bus.blank_mask = tbl[v].bl;
         wait_fd();
         for (int k = 0; k < 8; k++) begin
            chk($sformatf("tbl%0d_leg%0d", v, k), bus.leg, 8'hFF ^ (8'h01 << k));
            chk($sformatf("tbl%0d_dis%0d", v, k), bus.dis, tbl[v].e[k]);
            repeat (S) @(negedge clk);
         end
      end

      // One-cycle reset at idx 5
      bus.digits = 32'h55555555; bus.dp_mask = 8'hFF; bus.blank_mask = 8'h00;
      wait_fd();
      wait_leg(8'hDF);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_leg", bus.leg, 8'hFF);
      chk("midreset_dis", bus.dis, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      chk("restart_leg", bus.leg, 8'hFE);
      chk("restart_dis", bus.dis, 8'h3F);

`ifdef DISP_SCAN_BLINK_EN
      rst_n = 1'b0;
      bus.digits = 32'h76543210; bus.dp_mask = 8'h00;
      bus.blank_mask = 8'h00;    bus.blink_mask = 8'h01;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int f = 0; f < 5; f++) begin
         chk($sformatf("blink_f%0d_leg0", f), bus.leg, 8'hFE);
         chk($sformatf("blink_f%0d_dis0", f), bus.dis, (f == 2 || f == 3) ? 8'h00 : 8'h3F);
         repeat (S) @(negedge clk);
         chk($sformatf("blink_f%0d_dis1", f), bus.dis, (f == 0) ? 8'h3F : 8'h06);
         repeat (FRAME - S) @(negedge clk);
      end
`endif

      // Random inputs and occasional resets against the model
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 399) != 0);
         if ($urandom_range(0, 11) == 0) begin
            bus.digits     = $urandom;
            bus.dp_mask    = 8'($urandom);
            bus.blank_mask = 8'($urandom & $urandom);
            bus.blink_mask = 8'($urandom);
         end
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/disp_scan.md
# disp_scan

Time-multiplexed 8-digit seven-segment scan driver: the producer side of the digit-select/segment bus pair that the display mode selector routes to the board pins. It takes eight BCD digits plus decimal-point and blank masks, snapshots them once per frame, and walks one digit per scan slot. It drives an active-low one-hot digit select (`leg`) and active-high segment data (`dis`). One instance serves each display source: normal time, stopwatch, alarm.

## Interface
- `SCAN_DIV`, default 50000: clocks per digit slot; legal range ≥2.
- `BLINK_FRAMES`, default 16: frames per blink half-period; only used with the blink feature.
- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `digits` in 32: eight BCD nibbles; digit k = `digits[4k+3:4k]`; digit 0 is the leftmost display position.
- `dp_mask` in 8: bit k lights the decimal point of digit k.
- `blank_mask` in 8: bit k forces digit k fully dark (segments and dp).
- `blink_mask` in 8: bit k blinks digit k; the port is always present.
- `leg` out 8: digit select, active-low one-hot.
- `dis` out 8: segments {dp,g,f,e,d,c,b,a}, active-high.
- `frame_done` out 1: single-cycle pulse at the end of each 8-digit frame.

## Operation
- Slot counter `cnt` counts 0..SCAN_DIV-1. Its width is clog2(SCAN_DIV), minimum 1.
- `tick` = (`cnt`==SCAN_DIV-1). On `tick`, `cnt` returns to 0 and digit index `idx` (3 bits) increments mod 8, wrapping 7→0.
- Snapshot registers (`snap_digits`, `snap_dp`, `snap_blank`, `snap_blink`) load the inputs on the cycle where `tick` && `idx`==7. Input changes mid-frame are never visible mid-frame.
- Output register, loaded every cycle from `idx` and the snapshots:
  - `leg` = ~(8'b1 << `idx`).
  - `dis` = {`snap_dp[idx]`, seg(`snap_digits[idx]`)}, then forced to 0 if `snap_blank[idx]`.
- seg encoding (g..a): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F. Non-BCD values 10–15 → 00; the dp is still honoured.
- `frame_done` is registered: high for the one cycle after `tick` && `idx`==7.
- Reset values:
  - `leg`=8'hFF and `dis`=8'h00.
  - `frame_done`=0, `cnt`=0, `idx`=0.
  - All snapshot registers = 0. The first frame after reset therefore shows "00000000" with no dp and no blanking.
- Reset mid-frame: every register returns to its reset value on that edge. There is no partial-frame carryover.

## Timing
- Outputs lag `idx` by one cycle.
- First edge with `rst_n`=1 gives `leg`=8'hFE with digit 0 of the snapshot.
- Each digit is held for exactly SCAN_DIV cycles. A frame is 8·SCAN_DIV cycles.
- Input-to-display latency: the new value appears at the start of the next frame. Worst case is 8·SCAN_DIV+1 cycles.
- `frame_done` rises on the same edge at which `leg` becomes 8'hFE for the new frame.
- `leg` never has two zero bits in any cycle. There is no blanking gap between slots.

## Configuration
- Macro: `DISP_SCAN_BLINK_EN`.
- Defined:
  - A frame counter counts `frame_done` pulses 0..BLINK_FRAMES-1.
  - Blink `phase` toggles at wrap; it resets to 0, which is the visible phase.
  - While `phase`=1, any digit with `snap_blink[idx]`=1 has `dis`=0. `leg` still scans normally.
  - `phase` changes only on the `frame_done` edge.
- Undefined: `blink_mask` is ignored, there is no frame counter, and `phase` is constant 0.

## Structure
- Shared package `disp_pkg` holds:
  - `DIGITS`=8.
  - The seg-code constants for 0–9.
  - `SEG_OFF`=8'h00 and `LEG_OFF`=8'hFF.
  - The bit-position constant `DP_BIT`=7.
- One sub-module, `seg7_enc`: purely combinational 4-bit BCD → 7-bit segment decode, reused by other display producers.

## Test plan
- Reset with SCAN_DIV=4, digits=32'h76543210:
  - Expect `leg`=FF and `dis`=00 during reset.
  - The first frame shows 3F on all digits, with `leg` stepping FE,FD,…,7F every 4 cycles.
- Second frame, same setup: `dis` sequence is 3F,06,5B,4F,66,6D,7D,07 matched to `leg` FE…7F; `frame_done` pulses exactly once per 32 cycles.
- Change `digits` to 32'h99999999 while `idx`=3: the current frame is unchanged and the next frame shows 6F on all digits.
- dp_mask=8'h04 and blank_mask=8'h80: digit 2 `dis` has bit 7 set; digit 7 `dis`=00 while `leg`=7F; digit value 4'hC shows 00.
- Assert `rst_n`=0 for one cycle mid-frame at `idx`=5: the next edge gives `leg`=FF, then restart at FE with the snapshot zeroed.
- With `DISP_SCAN_BLINK_EN`, BLINK_FRAMES=2, blink_mask=8'h01: digit 0 is visible for frames 0–1, dark for frames 2–3, visible again in frame 4. Other digits are unaffected.
